ifft_4point_16bit: RTL



---
 rtl/ifft_4point_16bit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ifft_4point_16bit.sv
// Four-point radix-2 inverse FFT on packed {re[7:0], im[7:0]} words, result scaled by 1/4.
// Two registered butterfly stages behind a start/done handshake; outputs hold until the next completion.
module ifft_4point_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] freq0_in,
    input  logic [15:0] freq1_in,
    input  logic [15:0] freq2_in,
    input  logic [15:0] freq3_in,
    input  logic        start,
    output logic [15:0] sample0_out,
    output logic [15:0] sample1_out,
    output logic [15:0] sample2_out,
    output logic [15:0] sample3_out,
    output logic        done,
    output logic        busy
);

    // state    | meaning
    // S_IDLE   | waiting for start; bins latched on the accepting edge
    // S_STAGE1 | first butterfly stage (a0..a3) loads
    // S_STAGE2 | second stage, scale by 1/4, output registers load
    // S_DONE   | done pulse, back to S_IDLE
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STAGE1 = 2'd1,
        S_STAGE2 = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        x_q    [4];
    logic [15:0]        x_d    [4];
    logic signed [9:0]  a_re_q [4];
    logic signed [9:0]  a_re_d [4];
    logic signed [9:0]  a_im_q [4];
    logic signed [9:0]  a_im_d [4];
    logic [15:0]        y_q    [4];
    logic [15:0]        y_d    [4];
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    function automatic logic signed [9:0] re10(input logic [15:0] w);
        return {{2{w[15]}}, w[15:8]};
    endfunction

    function automatic logic signed [9:0] im10(input logic [15:0] w);
        return {{2{w[7]}}, w[7:0]};
    endfunction

    // Arithmetic shift floors toward -inf; the result always fits 8 bits.
    function automatic logic [7:0] scale(input logic signed [9:0] v);
        logic signed [9:0] s;
        s = v >>> 2;
        return s[7:0];
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_re_d  = a_re_q;
        a_im_d  = a_im_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d[0]  = freq0_in;
                    x_d[1]  = freq1_in;
                    x_d[2]  = freq2_in;
                    x_d[3]  = freq3_in;
                    state_d = S_STAGE1;
                end
            end
            S_STAGE1: begin
                a_re_d[0] = re10(x_q[0]) + re10(x_q[2]);
                a_im_d[0] = im10(x_q[0]) + im10(x_q[2]);
                a_re_d[1] = re10(x_q[0]) - re10(x_q[2]);
                a_im_d[1] = im10(x_q[0]) - im10(x_q[2]);
                a_re_d[2] = re10(x_q[1]) + re10(x_q[3]);
                a_im_d[2] = im10(x_q[1]) + im10(x_q[3]);
                a_re_d[3] = re10(x_q[1]) - re10(x_q[3]);
                a_im_d[3] = im10(x_q[1]) - im10(x_q[3]);
                state_d   = S_STAGE2;
            end
            S_STAGE2: begin
                // y1 = a1 + j*a3, y3 = a1 - j*a3
                y_d[0]  = {scale(a_re_q[0] + a_re_q[2]), scale(a_im_q[0] + a_im_q[2])};
                y_d[2]  = {scale(a_re_q[0] - a_re_q[2]), scale(a_im_q[0] - a_im_q[2])};
                y_d[1]  = {scale(a_re_q[1] - a_im_q[3]), scale(a_im_q[1] + a_re_q[3])};
                y_d[3]  = {scale(a_re_q[1] + a_im_q[3]), scale(a_im_q[1] - a_re_q[3])};
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                x_q[i]    <= '0;
                a_re_q[i] <= '0;
                a_im_q[i] <= '0;
                y_q[i]    <= '0;
            end
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_re_q  <= a_re_d;
            a_im_q  <= a_im_d;
            y_q     <= y_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sample0_out = y_q[0];
    assign sample1_out = y_q[1];
    assign sample2_out = y_q[2];
    assign sample3_out = y_q[3];
    assign done        = done_q;
    assign busy        = busy_q;

endmodule
